// File: rtl/iiitb_elc_pkg.sv
// iiitb_elc_pkg
// Shared definitions for the elevator request scheduler:
//   NUM_FLOORS    - number of floors (one bit per floor in every floor vector)
//   IDX_W         - width of an encoded floor index
//   sched_state_t - scheduler FSM states
//   onehot_to_idx - one-hot floor vector to encoded index
//   is_onehot     - true when exactly one bit of a floor vector is set
package iiitb_elc_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int IDX_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SERVE,
        ST_DWELL,
        ST_HOLD
    } sched_state_t;

    // OR-based encoder; only meaningful when the input is one-hot.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_FLOORS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - NUM_FLOORS'(1))) == '0);
    endfunction

endpackage

// File: rtl/iiitb_elc_floor_pick.sv
// iiitb_elc_floor_pick
// Combinational search of the outstanding call vector around the current floor.
// Ports:
//   pending     in  - outstanding call bits, bit i = floor i
//   cur_idx     in  - encoded index of the current floor
//   dir_up      in  - travel direction, 1 = upward
//   above       out - one-hot nearest pending floor strictly above cur_idx
//   above_found out - above is non-zero
//   below       out - one-hot nearest pending floor strictly below cur_idx
//   below_found out - below is non-zero
//   ahead_found out - a pending floor exists in the dir_up direction
module iiitb_elc_floor_pick
    import iiitb_elc_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic                  dir_up,
    output logic [NUM_FLOORS-1:0] above,
    output logic                  above_found,
    output logic [NUM_FLOORS-1:0] below,
    output logic                  below_found,
    output logic                  ahead_found
);

    // The last hit of each loop wins, so scanning from the far end toward
    // the current floor leaves the nearest candidate. Floors 0 and 7 are hard
    // limits: nothing wraps around.
    always_comb begin
        above = '0;
        below = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_idx))) begin
                above    = '0;
                above[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_idx))) begin
                below    = '0;
                below[i] = 1'b1;
            end
        end
    end

    assign above_found = |above;
    assign below_found = |below;
    assign ahead_found = dir_up ? above_found : below_found;

endmodule

// File: rtl/iiitb_elc_req_sched.sv
// iiitb_elc_req_sched
// Collects floor calls and hands one target floor at a time to the elevator
// controller, sweeping in one direction before reversing (SCAN order).
// Ports:
//   clk, reset     in  - clock, synchronous active-high reset
//   call_btn       in  - button presses, bit i = floor i
//   cur_floor      in  - one-hot current floor from the controller
//   complete       in  - controller arrival indication
//   door_alert     in  - door-timeout alarm
//   weight_alert   in  - overweight alarm
//   request_floor  out - one-hot target floor, 0 = no target
//   req_valid      out - request_floor holds a live target
//   pending        out - outstanding call register
//   sweep_up       out - scheduler travel direction, 1 = upward
//   floor_err      out - cur_floor is not one-hot
module iiitb_elc_req_sched
    import iiitb_elc_pkg::*;
#(
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic                  complete,
    input  logic                  door_alert,
    input  logic                  weight_alert,
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_up,
    output logic                  floor_err
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

    sched_state_t          state, state_n, hold_ret, hold_ret_n;
    logic [NUM_FLOORS-1:0] request_floor_n, pending_n, clear_mask;
    logic                  req_valid_n, sweep_up_n;
    logic [7:0]            dwell_cnt, dwell_cnt_n;

    logic [NUM_FLOORS-1:0] above, below, pick;
    logic                  above_found, below_found, ahead_found;
    logic                  alert, arrive;

    assign floor_err = !is_onehot(cur_floor);
    assign alert     = door_alert | weight_alert;
    assign arrive    = complete && (cur_floor == request_floor);

    iiitb_elc_floor_pick u_pick (
        .pending     (pending),
        .cur_idx     (onehot_to_idx(cur_floor)),
        .dir_up      (sweep_up),
        .above       (above),
        .above_found (above_found),
        .below       (below),
        .below_found (below_found),
        .ahead_found (ahead_found)
    );

    // Prefer the nearest call ahead; otherwise take the nearest one behind,
    // which reverses the sweep.
    always_comb begin
        if (ahead_found) begin
            pick = sweep_up ? above : below;
        end else begin
            pick = sweep_up ? below : above;
        end
    end

    // Next-state and next-output logic. Everything holds by default; HOLD
    // relies on that to freeze the target and dwell count.
    always_comb begin
        state_n         = state;
        hold_ret_n      = hold_ret;
        request_floor_n = request_floor;
        req_valid_n     = req_valid;
        sweep_up_n      = sweep_up;
        dwell_cnt_n     = dwell_cnt;
        clear_mask      = '0;

        case (state)
            ST_IDLE: begin
                clear_mask = cur_floor;
                if ((pending != '0) && !floor_err) begin
                    state_n = ST_SELECT;
                end
            end
            // With a corrupt floor reading the search index is meaningless,
            // so SELECT simply waits for a clean reading.
            ST_SELECT: begin
                if (!floor_err) begin
                    if (above_found || below_found) begin
                        request_floor_n = pick;
                        req_valid_n     = 1'b1;
                        sweep_up_n      = ahead_found ? sweep_up : !sweep_up;
                        state_n         = ST_SERVE;
                    end else begin
                        request_floor_n = '0;
                        req_valid_n     = 1'b0;
                        state_n         = ST_IDLE;
                    end
                end
            end
            ST_SERVE: begin
                if (floor_err) begin
                    state_n = ST_SERVE;
                end else if (alert) begin
                    hold_ret_n = ST_SERVE;
                    state_n    = ST_HOLD;
                end else if (arrive) begin
                    clear_mask      = request_floor;
                    request_floor_n = '0;
                    req_valid_n     = 1'b0;
                    dwell_cnt_n     = '0;
                    state_n         = ST_DWELL;
                end
            end
            ST_DWELL: begin
                clear_mask = cur_floor;
                if (alert) begin
                    hold_ret_n = ST_DWELL;
                    state_n    = ST_HOLD;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt_n = '0;
                    state_n     = (pending != '0) ? ST_SELECT : ST_IDLE;
                end else begin
                    dwell_cnt_n = dwell_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!alert) begin
                    state_n = hold_ret;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Clearing is applied last so it wins over a press on the same floor.
        pending_n = (pending | call_btn) & ~clear_mask;
    end

    // Single state register for the whole block; reset also drops presses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            hold_ret      <= ST_IDLE;
            pending       <= '0;
            request_floor <= '0;
            req_valid     <= 1'b0;
            sweep_up      <= 1'b1;
            dwell_cnt     <= '0;
        end else begin
            state         <= state_n;
            hold_ret      <= hold_ret_n;
            pending       <= pending_n;
            request_floor <= request_floor_n;
            req_valid     <= req_valid_n;
            sweep_up      <= sweep_up_n;
            dwell_cnt     <= dwell_cnt_n;
        end
    end

endmodule

// File: doc/iiitb_elc_req_sched.md
IIITB_ELC_REQ_SCHED -- requirements
Module: iiitb_elc_req_sched

Interface
REQ-001 Parameter DWELL_CYCLES, default 8, SHALL set the door dwell time in clk cycles after arrival, legal range 1..255.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: SHALL be a synchronous, active-high reset.
REQ-004 Port call_btn, input, 8: SHALL carry one bit per floor for car/hall button presses; bit i is floor i; several bits may be high at once.
REQ-005 Port cur_floor, input, 8: SHALL carry the one-hot current floor from the elevator controller.
REQ-006 Port complete, input, 1: SHALL be the controller's arrival indication.
REQ-007 Port door_alert, input, 1: SHALL be the controller's door-timeout alarm.
REQ-008 Port weight_alert, input, 1: SHALL be the controller's overweight alarm.
REQ-009 Port request_floor, output, 8: SHALL carry the one-hot target floor to the controller; 0 means no target.
REQ-010 Port req_valid, output, 1: SHALL be high while request_floor holds a live target.
REQ-011 Port pending, output, 8: SHALL expose the outstanding call register.
REQ-012 Port sweep_up, output, 1: SHALL give the scheduler travel direction; 1 = upward.
REQ-013 Port floor_err, output, 1: SHALL be high when cur_floor is not one-hot.

Function
REQ-014 pending SHALL be updated as pending <= (pending | call_btn) & ~clear_mask every cycle, where clear_mask is the served floor on the arrival cycle and cur_floor while in IDLE or DWELL; clear SHALL win over a simultaneous press.
REQ-015 The FSM SHALL have the states IDLE, SELECT, SERVE, DWELL and HOLD.
REQ-016 IDLE -> SELECT SHALL occur when pending != 0 and floor_err = 0.
REQ-017 On SELECT exit, the block SHALL register the target into request_floor, set req_valid, and go to SERVE.
REQ-018 Target rule: search in the sweep_up direction for the nearest pending bit strictly beyond cur_floor; if none exists, invert sweep_up and search the other way; if pending becomes empty, return to IDLE with req_valid = 0.
REQ-019 request_floor SHALL stay stable throughout SERVE; new presses SHALL only set pending bits.
REQ-020 SERVE -> DWELL SHALL occur when complete = 1 and cur_floor == request_floor.
REQ-021 On the SERVE -> DWELL edge, the block SHALL clear the served pending bit and drive req_valid = 0 and request_floor = 0.
REQ-022 DWELL SHALL count DWELL_CYCLES cycles, then go to SELECT if pending != 0, otherwise to IDLE.
REQ-023 Latency: a press sampled at edge k from IDLE SHALL produce a valid request_floor after edge k+2.
REQ-024 When door_alert or weight_alert is high in SERVE or DWELL, the FSM SHALL enter HOLD.
REQ-025 In HOLD, request_floor, req_valid and the dwell count SHALL be frozen while pending keeps accumulating.
REQ-026 When both alerts are low, HOLD SHALL return to the state it left on the next edge.
REQ-027 When cur_floor is not one-hot, floor_err SHALL assert combinationally, no IDLE -> SELECT transition SHALL occur, and an active SERVE SHALL be kept unchanged.
REQ-028 Floor-index comparisons SHALL use the 3-bit encoded index of cur_floor; floor 0 and floor 7 are hard limits with no wrap-around.

Reset
REQ-029 On reset high at a rising edge, the block SHALL set state = IDLE, pending = 0, request_floor = 0, req_valid = 0, sweep_up = 1 and dwell count = 0, discarding any in-flight target.
REQ-030 call_btn SHALL be ignored on any edge where reset is high.

Structure
REQ-031 Package iiitb_elc_pkg SHALL hold NUM_FLOORS = 8, the FSM state enum, and the one-hot-to-index and is-one-hot functions.
REQ-032 Combinational sub-module iiitb_elc_floor_pick SHALL take pending, the current index and a direction, and return the nearest-above and nearest-below one-hot floors plus their found flags.
REQ-033 All state SHALL be held in a single clocked process.

Verification
REQ-034 Scenario 1: cur_floor = 0x01 and call_btn pulses 0x10 at edge k -> request_floor = 0x10 and req_valid = 1 after edge k+2, with sweep_up = 1.
REQ-035 Scenario 2: cur_floor = 0x08, sweep_up = 1, pending = 0x41 -> target 0x40; after arrival and dwell -> target 0x01, with sweep_up = 0.
REQ-036 Scenario 3: SERVE with target 0x20 and weight_alert raised for 5 cycles -> request_floor is held at 0x20 and DWELL is not entered; after the alert drops, arrival proceeds normally.
REQ-037 Scenario 4: arrival at 0x04 with call_btn = 0x04 on the same cycle -> pending bit 2 = 0 and DWELL lasts exactly 8 cycles.
REQ-038 Scenario 5: cur_floor = 0x03 in IDLE with pending = 0x80 -> floor_err = 1 and request_floor stays 0.
REQ-039 Scenario 6: reset asserted mid-SERVE with target 0x80 -> on the next edge all outputs are 0, sweep_up = 1 and the state is IDLE.
